// File: rtl/task_scheduler_param.sv
// Task scheduler: walks CF/IF frames in task memory, streams IF beats to the cores, pulses start.
// Define TS_FRAME_SYNC_EN to enable the stop-frame display handshake (STOP_WAIT state).
module task_scheduler_param #(
    parameter int NUM_CORES = 16,
    parameter int TM_AW     = 8,
    parameter int BEATS     = 8,
    parameter int BEAT_W    = 64,
    parameter int R0_W      = 8,
    localparam int FRAME_W  = BEATS * BEAT_W,
    localparam int CNT_W    = $clog2(BEATS)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    output logic                      tm_rd_en_o,
    output logic [TM_AW-1:0]          tm_addr_o,
    input  logic [FRAME_W-1:0]        tm_data_i,
    input  logic [NUM_CORES-1:0]      ready_i,
    output logic [NUM_CORES-1:0]      start_o,
    output logic                      insn_valid_o,
    output logic [CNT_W-1:0]          insn_load_cnt_o,
    output logic [BEAT_W-1:0]         insn_data_o,
    output logic [NUM_CORES-1:0]      init_r0_vect_o,
    output logic [NUM_CORES*R0_W-1:0] init_r0_o,
    input  logic                      frame_end_i,
    output logic                      frame_en_o
);
    localparam int STOP_LSB  = 11;
    localparam int MASK_LSB  = 11 + TM_AW;
    localparam int RMASK_LSB = MASK_LSB + NUM_CORES;
    localparam int R0_LSB    = RMASK_LSB + NUM_CORES;
    localparam logic [1:0] FENCE_ACQ = 2'b01;
    localparam logic [1:0] FENCE_REL = 2'b10;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [3:0] {
        FETCH_CF, DECODE, FENCE_WAIT, FETCH_IF, READY_WAIT, LOAD, START, DRAIN, STOP_WAIT
    } state_t;

    state_t                  state_q, state_d, stop_state;
    logic [TM_AW-1:0]        ptr_q, ptr_d, stop_ptr;
    logic [7:0]              if_cnt_q, if_cnt_d;
    logic [1:0]              fence_q;
    logic                    stop_q;
    logic [TM_AW-1:0]        stop_addr_q;
    logic [NUM_CORES-1:0]    core_mask_q;
    logic [FRAME_W-1:0]      frame_q, frame_src;
    logic                    rw_first_q;
    logic                    tm_rd_en_q, tm_rd_en_d;
    logic [NUM_CORES-1:0]    start_q, start_d;
    logic                    insn_valid_q, insn_valid_d;
    logic [CNT_W-1:0]        insn_load_cnt_q, insn_load_cnt_d, beat_idx;
    logic [BEAT_W-1:0]       insn_data_q, insn_data_d;
    logic [NUM_CORES-1:0]    init_r0_vect_q;
    logic [NUM_CORES*R0_W-1:0] init_r0_q;
    logic                    mask_ok, all_ok;

    assign mask_ok  = (ready_i & core_mask_q) == core_mask_q;
    assign all_ok   = &ready_i;
    assign stop_ptr = stop_q ? stop_addr_q : ptr_q;
    // Memory data arrives only in the first READY_WAIT cycle; afterwards the captured copy is used.
    assign frame_src = rw_first_q ? tm_data_i : frame_q;
    assign beat_idx  = (state_q == LOAD) ? insn_load_cnt_q + CNT_W'(1) : '0;

`ifdef TS_FRAME_SYNC_EN
    logic frame_en_q, frame_en_d, sent_q, sent_d, frame_end_q;
    assign stop_state = stop_q ? STOP_WAIT : FETCH_CF;
    assign frame_en_o = frame_en_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            frame_en_q  <= 1'b0;
            sent_q      <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            frame_en_q  <= frame_en_d;
            sent_q      <= sent_d;
            frame_end_q <= frame_end_i;
        end
    end
`else
    logic unused_frame_end;
    assign unused_frame_end = frame_end_i;
    assign stop_state       = FETCH_CF;
    assign frame_en_o       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        if_cnt_d = if_cnt_q;
`ifdef TS_FRAME_SYNC_EN
        frame_en_d = 1'b0;
        sent_d     = sent_q;
`endif
        case (state_q)
            // After reset the read strobe is still low, so hold one cycle to issue the read.
            FETCH_CF: if (tm_rd_en_q) state_d = DECODE;
            DECODE: begin
                if_cnt_d = tm_data_i[7:0];
                ptr_d    = ptr_q + TM_AW'(1);
                state_d  = FENCE_WAIT;
            end
            FENCE_WAIT: begin
                if ((fence_q == FENCE_ACQ) ? all_ok : mask_ok) begin
                    if (if_cnt_q != 8'd0) begin
                        state_d = FETCH_IF;
                    end else if (fence_q == FENCE_REL) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = stop_state;
                        ptr_d   = stop_ptr;
                    end
                end
            end
            FETCH_IF:   state_d = READY_WAIT;
            READY_WAIT: if (mask_ok) state_d = LOAD;
            LOAD:       if (insn_load_cnt_q == LAST_BEAT) state_d = START;
            START: begin
                if_cnt_d = if_cnt_q - 8'd1;
                ptr_d    = ptr_q + TM_AW'(1);
                if (if_cnt_q != 8'd1) begin
                    state_d = FETCH_IF;
                end else if (fence_q == FENCE_REL) begin
                    state_d = DRAIN;
                end else begin
                    state_d = stop_state;
                    if (stop_q) ptr_d = stop_addr_q;
                end
            end
            DRAIN: begin
                if (all_ok) begin
                    state_d = stop_state;
                    ptr_d   = stop_ptr;
                end
            end
`ifdef TS_FRAME_SYNC_EN
            STOP_WAIT: begin
                // Edges only count once frame_en has gone out, so a level already high is ignored.
                if (!sent_q) begin
                    if (all_ok) begin
                        frame_en_d = 1'b1;
                        sent_d     = 1'b1;
                    end
                end else if (frame_end_i && !frame_end_q) begin
                    sent_d  = 1'b0;
                    state_d = FETCH_CF;
                end
            end
`else
            STOP_WAIT:  state_d = FETCH_CF;
`endif
            default:    state_d = FETCH_CF;
        endcase

        tm_rd_en_d      = (state_d == FETCH_CF) || (state_d == FETCH_IF);
        start_d         = (state_d == START) ? core_mask_q : '0;
        insn_valid_d    = (state_d == LOAD);
        insn_load_cnt_d = (state_d == LOAD) ? beat_idx : '0;
        insn_data_d     = (state_d == LOAD) ? frame_src[int'(beat_idx)*BEAT_W +: BEAT_W] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q         <= FETCH_CF;
            ptr_q           <= '0;
            rw_first_q      <= 1'b0;
            tm_rd_en_q      <= 1'b0;
            start_q         <= '0;
            insn_valid_q    <= 1'b0;
            insn_load_cnt_q <= '0;
            insn_data_q     <= '0;
            init_r0_vect_q  <= '0;
            init_r0_q       <= '0;
        end else begin
            state_q         <= state_d;
            ptr_q           <= ptr_d;
            rw_first_q      <= (state_q == FETCH_IF);
            tm_rd_en_q      <= tm_rd_en_d;
            start_q         <= start_d;
            insn_valid_q    <= insn_valid_d;
            insn_load_cnt_q <= insn_load_cnt_d;
            insn_data_q     <= insn_data_d;
            if (state_q == DECODE) begin
                init_r0_vect_q <= tm_data_i[RMASK_LSB +: NUM_CORES];
                init_r0_q      <= tm_data_i[R0_LSB +: NUM_CORES*R0_W];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if_cnt_q <= if_cnt_d;
        if (state_q == DECODE) begin
            fence_q     <= tm_data_i[9:8];
            stop_q      <= tm_data_i[10];
            stop_addr_q <= tm_data_i[STOP_LSB +: TM_AW];
            core_mask_q <= tm_data_i[MASK_LSB +: NUM_CORES];
        end
        if (rw_first_q) frame_q <= tm_data_i;
    end

    assign tm_rd_en_o      = tm_rd_en_q;
    assign tm_addr_o       = ptr_q;
    assign start_o         = start_q;
    assign insn_valid_o    = insn_valid_q;
    assign insn_load_cnt_o = insn_load_cnt_q;
    assign insn_data_o     = insn_data_q;
    assign init_r0_vect_o  = init_r0_vect_q;
    assign init_r0_o       = init_r0_q;

endmodule

// File: tb/tb_task_scheduler_param.sv
// Scoreboard bench for task_scheduler_param: expected fetches, beats and start pulses are queued
// by the stimulus and checked by a monitor whenever the DUT presents them.
module tb_task_scheduler_param;
    logic         clk = 1'b0;
    logic         reset;
    logic         tm_rd_en;
    logic [7:0]   tm_addr;
    logic [511:0] tm_data = '0;
    logic [15:0]  ready;
    logic [15:0]  start;
    logic         insn_valid;
    logic [2:0]   insn_load_cnt;
    logic [63:0]  insn_data;
    logic [15:0]  init_r0_vect;
    logic [127:0] init_r0;
    logic         frame_end;
    logic         frame_en;

    logic [511:0] mem [0:255];
    logic [7:0]   exp_fetch[$];
    logic [66:0]  exp_beat[$];
    logic [15:0]  exp_start[$];
    int           total = 0;
    int           bad = 0;
    int           cyc = 0;
    logic         mon_en = 1'b0;
    logic [7:0]   m_addr;
    logic [66:0]  m_beat;
    logic [15:0]  m_start;

    task_scheduler_param dut (
        .clk_i(clk), .reset_i(reset), .tm_rd_en_o(tm_rd_en), .tm_addr_o(tm_addr),
        .tm_data_i(tm_data), .ready_i(ready), .start_o(start), .insn_valid_o(insn_valid),
        .insn_load_cnt_o(insn_load_cnt), .insn_data_o(insn_data), .init_r0_vect_o(init_r0_vect),
        .init_r0_o(init_r0), .frame_end_i(frame_end), .frame_en_o(frame_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (tm_rd_en) tm_data <= mem[tm_addr];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_beat(input int id, input int k);
        return {32'(id) ^ 32'hB0C0_0000, 32'(k) ^ 32'h5A5A_A5A5};
    endfunction

    function automatic logic [511:0] mk_cf(input logic [7:0] n, input logic [1:0] f, input logic s,
                                           input logic [7:0] sa, input logic [15:0] cm,
                                           input logic [15:0] rm, input logic [127:0] r0);
        logic [511:0] w;
        w = '0;
        w[7:0] = n; w[9:8] = f; w[10] = s; w[18:11] = sa;
        w[34:19] = cm; w[50:35] = rm; w[178:51] = r0;
        return w;
    endfunction

    task automatic load_if(input int a, input int id);
        for (int k = 0; k < 8; k++) mem[a][k*64 +: 64] = mk_beat(id, k);
    endtask

    task automatic push_beats(input int id, input int n);
        for (int k = 0; k < n; k++) exp_beat.push_back({3'(k), mk_beat(id, k)});
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        clear_mem();
    endtask

    task automatic wait_drain(input string name, input int maxc);
        int n;
        n = 0;
        while ((exp_fetch.size() + exp_beat.size() + exp_start.size()) != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drained"}, 128'(exp_fetch.size() + exp_beat.size() + exp_start.size()), 128'(0));
        exp_fetch.delete();
        exp_beat.delete();
        exp_start.delete();
    endtask

    task automatic wait_fetch_at(input logic [7:0] a, input int maxc, output int c);
        c = -1;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (tm_rd_en && tm_addr == a) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("timeout_fetch", 128'(0), 128'(1));
    endtask

    task automatic wait_start(input int maxc, output int c);
        c = -1;
        for (int n = 0; n < maxc; n++) begin
            @(negedge clk);
            if (start != 16'h0) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("timeout_start", 128'(0), 128'(1));
    endtask

    task automatic count_window(input int n, output int rd, output int fe, output int st);
        rd = 0; fe = 0; st = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tm_rd_en) rd++;
            if (frame_en) fe++;
            if (start != 16'h0) st++;
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (tm_rd_en && exp_fetch.size() > 0) begin
                m_addr = exp_fetch.pop_front();
                chk("fetch_addr", 128'(tm_addr), 128'(m_addr));
            end
            if (insn_valid) begin
                if (exp_beat.size() == 0) chk("beat_unexpected", 128'(insn_valid), 128'(0));
                else begin
                    m_beat = exp_beat.pop_front();
                    chk("beat", 128'({insn_load_cnt, insn_data}), 128'(m_beat));
                end
            end
            if (start != 16'h0) begin
                if (exp_start.size() == 0) chk("start_unexpected", 128'(start), 128'(0));
                else begin
                    m_start = exp_start.pop_front();
                    chk("start_mask", 128'(start), 128'(m_start));
                end
            end
        end
    end

    initial begin
        int t0, t1, rd, fe, st;
        reset = 1'b1; ready = 16'hFFFF; frame_end = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        chk("rst_tm_rd_en", 128'(tm_rd_en), 128'(0));
        chk("rst_start", 128'(start), 128'(0));
        chk("rst_insn_valid", 128'(insn_valid), 128'(0));
        chk("rst_load_cnt", 128'(insn_load_cnt), 128'(0));
        chk("rst_insn_data", 128'(insn_data), 128'(0));
        chk("rst_r0_vect", 128'(init_r0_vect), 128'(0));
        chk("rst_r0", init_r0, 128'(0));
        chk("rst_frame_en", 128'(frame_en), 128'(0));
        chk("rst_tm_addr", 128'(tm_addr), 128'(0));
        mon_en = 1'b1;

        // Single IF, fence NO, cores 0/1
        mem[0] = mk_cf(8'd1, 2'b00, 1'b0, 8'h00, 16'h0003, 16'h0002, 128'hA5 << 8);
        load_if(1, 1);
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        push_beats(1, 8); exp_start.push_back(16'h0003); exp_fetch.push_back(8'h02);
        reset = 1'b0;
        wait_fetch_at(8'h01, 40, t0);
        wait_start(40, t1);
        chk("if_to_start_cycles", 128'(t1 - t0), 128'(10));
        chk("init_r0_vect", 128'(init_r0_vect), 128'(16'h0002));
        chk("init_r0_core1", 128'(init_r0[15:8]), 128'(8'hA5));
        wait_drain("single_if", 40);

        // ACQ fence blocked by core 5
        do_reset();
        ready = 16'hFFDF;
        mem[0] = mk_cf(8'd1, 2'b01, 1'b0, 8'h00, 16'h0001, 16'h0, 128'h0);
        load_if(1, 2);
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        push_beats(2, 8); exp_start.push_back(16'h0001); exp_fetch.push_back(8'h02);
        reset = 1'b0;
        count_window(20, rd, fe, st);
        chk("acq_hold_fetches", 128'(rd), 128'(1));
        chk("acq_hold_starts", 128'(st), 128'(0));
        ready = 16'hFFFF;
        wait_drain("acq", 60);

        // REL fence, two IFs; core 8 (outside the mask) busy holds only the drain
        do_reset();
        ready = 16'hFEFF;
        mem[0] = mk_cf(8'd2, 2'b10, 1'b0, 8'h00, 16'h000F, 16'h0, 128'h0);
        load_if(1, 3); load_if(2, 4);
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        push_beats(3, 8); exp_start.push_back(16'h000F); exp_fetch.push_back(8'h02);
        push_beats(4, 8); exp_start.push_back(16'h000F);
        reset = 1'b0;
        wait_start(40, t0);
        wait_start(40, t1);
        count_window(15, rd, fe, st);
        chk("rel_drain_hold_fetches", 128'(rd), 128'(0));
        exp_fetch.push_back(8'h03);
        ready = 16'hFFFF;
        wait_drain("rel", 20);

        // Stop frame to 0x40
        do_reset();
        mem[0] = mk_cf(8'd0, 2'b00, 1'b1, 8'h40, 16'h0, 16'h0, 128'h0);
`ifdef TS_FRAME_SYNC_EN
        frame_end = 1'b1;
        exp_fetch.push_back(8'h00);
        reset = 1'b0;
        count_window(20, rd, fe, st);
        chk("stop_frame_en_pulses", 128'(fe), 128'(1));
        chk("stop_hold_fetches", 128'(rd), 128'(1));
        frame_end = 1'b0;
        count_window(3, rd, fe, st);
        chk("stop_fall_no_fetch", 128'(rd), 128'(0));
        exp_fetch.push_back(8'h40);
        frame_end = 1'b1;
        wait_drain("stop_sync", 10);
        frame_end = 1'b0;
`else
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h40);
        reset = 1'b0;
        wait_fetch_at(8'h00, 10, t0);
        wait_fetch_at(8'h40, 10, t1);
        chk("stop_jump_cycles", 128'(t1 - t0), 128'(3));
        count_window(10, rd, fe, st);
        chk("stop_frame_en_low", 128'(fe), 128'(0));
        wait_drain("stop_nosync", 5);
`endif

        // Pointer wrap through 0xFF
        do_reset();
        for (int a = 0; a < 256; a++) exp_fetch.push_back(8'(a));
        exp_fetch.push_back(8'h00);
        reset = 1'b0;
        wait_drain("wrap", 900);

        // Reset during LOAD
        do_reset();
        mem[0] = mk_cf(8'd1, 2'b00, 1'b0, 8'h00, 16'h0003, 16'h0, 128'h0);
        load_if(1, 5);
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        push_beats(5, 4);
        reset = 1'b0;
        t0 = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (insn_valid && insn_load_cnt == 3'd3) begin
                t0 = n;
                break;
            end
        end
        if (t0 < 0) chk("timeout_load", 128'(0), 128'(1));
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_insn_valid", 128'(insn_valid), 128'(0));
        chk("midrst_start", 128'(start), 128'(0));
        chk("midrst_tm_addr", 128'(tm_addr), 128'(0));
        chk("midrst_queue_empty", 128'(exp_fetch.size() + exp_beat.size()), 128'(0));
        exp_fetch.push_back(8'h00); exp_fetch.push_back(8'h01);
        push_beats(5, 8); exp_start.push_back(16'h0003); exp_fetch.push_back(8'h02);
        reset = 1'b0;
        wait_drain("midrst_restart", 60);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
